// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-subsystem types: bus widths, arbiter state and grant encodings.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package riscv_pkg;

    localparam int ADDR_W = `RISCV_ADDR_WIDTH;
    localparam int WORD_W = `RISCV_WORD_WIDTH;
    localparam int WE_W   = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // {d_granted, i_granted}
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_I    = 2'b01,
        GNT_D    = 2'b10
    } grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one single-port RAM, round robin on ties,
// with a per-access watchdog that aborts a grant the RAM never answers.
//   state  | meaning
//   IDLE   | no access in flight, arbitrate pending requests
//   BUSY_I | instruction port owns the RAM
//   BUSY_D | data port owns the RAM
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         imem_valid_i,
    output logic                         imem_ready_o,
    input  logic [`RISCV_ADDR_WIDTH-1:0] imem_addr_i,
    input  logic [`RISCV_WORD_WIDTH-1:0] imem_wdata_i,
    input  logic [3:0]                   imem_we_i,
    output logic [`RISCV_WORD_WIDTH-1:0] imem_rdata_o,
    input  logic                         dmem_valid_i,
    output logic                         dmem_ready_o,
    input  logic [`RISCV_ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [`RISCV_WORD_WIDTH-1:0] dmem_wdata_i,
    input  logic [3:0]                   dmem_we_i,
    output logic [`RISCV_WORD_WIDTH-1:0] dmem_rdata_o,
    output logic                         mem_valid_o,
    input  logic                         mem_ready_i,
    output logic [`RISCV_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [`RISCV_WORD_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]                   mem_we_o,
    input  logic [`RISCV_WORD_WIDTH-1:0] mem_rdata_i,
    output logic                         timeout_o,
    output logic [1:0]                   grant_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    arb_state_e       state_q, state_d;
    grant_e           last_q, last_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;

    logic                         sel_d;
    logic                         req_valid;
    logic [`RISCV_ADDR_WIDTH-1:0] req_addr;
    logic [`RISCV_WORD_WIDTH-1:0] req_wdata;
    logic [3:0]                   req_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= GNT_D;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Request fields are forwarded live from the owning port, never latched.
    assign sel_d     = (state_q == BUSY_D);
    assign req_valid = sel_d ? dmem_valid_i : imem_valid_i;
    assign req_addr  = sel_d ? dmem_addr_i  : imem_addr_i;
    assign req_wdata = sel_d ? dmem_wdata_i : imem_wdata_i;
    assign req_we    = sel_d ? dmem_we_i    : imem_we_i;

    assign wait_cnt_inc = (wait_cnt_q == {CNT_W{1'b1}}) ? wait_cnt_q : wait_cnt_q + 1'b1;
    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        wait_cnt_d   = wait_cnt_q;
        mem_valid_o  = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_we_o     = '0;
        imem_ready_o = 1'b0;
        dmem_ready_o = 1'b0;
        timeout_o    = 1'b0;
        grant_o      = GNT_NONE;

        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (imem_valid_i && dmem_valid_i) begin
                    state_d = (last_q == GNT_D) ? BUSY_I : BUSY_D;
                end else if (imem_valid_i) begin
                    state_d = BUSY_I;
                end else if (dmem_valid_i) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                grant_o      = sel_d ? GNT_D : GNT_I;
                mem_valid_o  = req_valid;
                mem_addr_o   = req_addr;
                mem_wdata_o  = req_wdata;
                mem_we_o     = req_we;
                imem_ready_o = !sel_d && mem_ready_i;
                dmem_ready_o = sel_d && mem_ready_i;
                if (!req_valid) begin
                    // Requester withdrew: release the RAM without touching fairness.
                    state_d = IDLE;
                end else if (mem_ready_i) begin
                    last_d  = sel_d ? GNT_D : GNT_I;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == TIMEOUT_CNT) begin
                        timeout_o = 1'b1;
                        last_d    = sel_d ? GNT_D : GNT_I;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected RAM handshakes are queued as stimulus is
// driven and checked by a monitor when the handshake appears on the RAM side.
module tb_mem_arbiter;
    import riscv_pkg::*;

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              iv = 1'b0, dv = 1'b0, mrdy = 1'b0;
    logic [ADDR_W-1:0] ia = '0, da = '0;
    logic [WORD_W-1:0] iw = '0, dw = '0, mrdata = '0;
    logic [3:0]        iwe = '0, dwe = '0;

    logic              imem_ready, dmem_ready, mem_valid, timeout;
    logic [WORD_W-1:0] imem_rdata, dmem_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [1:0]        grant;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t e;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_valid_i(iv), .imem_ready_o(imem_ready), .imem_addr_i(ia),
        .imem_wdata_i(iw), .imem_we_i(iwe), .imem_rdata_o(imem_rdata),
        .dmem_valid_i(dv), .dmem_ready_o(dmem_ready), .dmem_addr_i(da),
        .dmem_wdata_i(dw), .dmem_we_i(dwe), .dmem_rdata_o(dmem_rdata),
        .mem_valid_o(mem_valid), .mem_ready_i(mrdy), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .mem_rdata_i(mrdata),
        .timeout_o(timeout), .grant_o(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_mvalid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_iready"}, 32'(imem_ready), 32'd0);
        chk({tag, "_dready"}, 32'(dmem_ready), 32'd0);
        chk({tag, "_addr"}, mem_addr, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    endtask

    task automatic push(input logic [1:0] g, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] we);
        exp_t x;
        x.gnt = g; x.addr = a; x.wdata = w; x.we = we;
        sb.push_back(x);
    endtask

    // Scoreboard monitor: every completed RAM handshake must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && mem_valid && mrdy) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_hs_grant", 32'(grant), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_grant", 32'(grant), 32'(e.gnt));
                chk("sb_addr", mem_addr, e.addr);
                chk("sb_wdata", mem_wdata, e.wdata);
                chk("sb_we", 32'(mem_we), 32'(e.we));
                chk("sb_iready", 32'(imem_ready), 32'(e.gnt == 2'b01));
                chk("sb_dready", 32'(dmem_ready), 32'(e.gnt == 2'b10));
                chk("sb_rdata", (e.gnt == 2'b01) ? imem_rdata : dmem_rdata, mrdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single instruction access, RAM ready on the second BUSY cycle
        tick();
        iv = 1'b1; ia = 32'h100; mrdata = 32'hA5A5_0001;
        push(2'b01, 32'h100, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_idle_mvalid", 32'(mem_valid), 32'd0);
        chk("t1_idle_grant", 32'(grant), 32'd0);
        tick();
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_iready_wait", 32'(imem_ready), 32'd0);
        tick();
        mrdy = 1'b1;
        @(negedge clk);
        chk("t1_iready_hs", 32'(imem_ready), 32'd1);
        tick();
        iv = 1'b0; mrdy = 1'b0;
        @(negedge clk);
        chk("t1_back_idle_grant", 32'(grant), 32'd0);
        chk("t1_back_idle_iready", 32'(imem_ready), 32'd0);

        // Round robin from reset, both requesting, RAM always ready
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        iv = 1'b1; dv = 1'b1; ia = 32'h10; da = 32'h20; mrdy = 1'b1; mrdata = 32'h0BAD_F00D;
        push(2'b01, 32'h10, 32'h0, 4'h0);
        push(2'b10, 32'h20, 32'h0, 4'h0);
        push(2'b01, 32'h10, 32'h0, 4'h0);
        push(2'b10, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        chk("t2_idle_mvalid", 32'(mem_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 7) begin
                iv = 1'b0; dv = 1'b0;
            end
            @(negedge clk);
            if (k % 2 == 1) begin
                chk("t2_gap_grant", 32'(grant), 32'd0);
            end else begin
                chk("t2_grant", 32'(grant), (k % 4 == 0) ? 32'd1 : 32'd2);
                chk("t2_addr", mem_addr, (k % 4 == 0) ? 32'h10 : 32'h20);
            end
        end
        mrdy = 1'b0;

        // Data write while instruction request is pending; live field forwarding
        tick();
        dv = 1'b1; da = 32'h40; dw = 32'hDEAD_BEEF; dwe = 4'b0011;
        push(2'b10, 32'h40, 32'hDEAD_BEEF, 4'b0011);
        @(negedge clk);
        tick();
        iv = 1'b1; ia = 32'h50;
        @(negedge clk);
        chk("t3_grant", 32'(grant), 32'd2);
        chk("t3_we", 32'(mem_we), 32'h3);
        chk("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t3_iready_a", 32'(imem_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("t3_iready_b", 32'(imem_ready), 32'd0);
        tick();
        mrdy = 1'b1;
        @(negedge clk);
        chk("t3_iready_c", 32'(imem_ready), 32'd0);
        tick();
        dv = 1'b0; mrdy = 1'b0;
        @(negedge clk);
        chk("t3_idle_grant", 32'(grant), 32'd0);
        chk("t3_idle_we", 32'(mem_we), 32'd0);
        chk("t3_idle_wdata", mem_wdata, 32'd0);
        tick();
        @(negedge clk);
        chk("t3_i_grant", 32'(grant), 32'd1);
        chk("t3_i_addr", mem_addr, 32'h50);
        tick();
        ia = 32'h54; mrdy = 1'b1;
        push(2'b01, 32'h54, 32'h0, 4'h0);
        @(negedge clk);
        chk("t3_fwd_addr", mem_addr, 32'h54);
        tick();
        iv = 1'b0; mrdy = 1'b0;

        // Reset in the middle of a data access; instruction port then wins the tie
        dv = 1'b1; da = 32'h90; dw = '0; dwe = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t5_pre_grant", 32'(grant), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk_quiet("t5_in_reset");
        iv = 1'b1; ia = 32'h10; da = 32'h20; mrdy = 1'b1;
        push(2'b01, 32'h10, 32'h0, 4'h0);
        push(2'b10, 32'h20, 32'h0, 4'h0);
        tick();
        chk_quiet("t5_held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_first_grant", 32'(grant), 32'd1);
        tick();
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t5_second_grant", 32'(grant), 32'd2);
        tick();
        iv = 1'b0; dv = 1'b0; mrdy = 1'b0;

        // Watchdog: RAM never ready, TIMEOUT=4
        tick();
        dv = 1'b1; da = 32'h80;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            tick();
            @(negedge clk);
            chk("t4_grant", 32'(grant), 32'd2);
            chk("t4_dready", 32'(dmem_ready), 32'd0);
            chk("t4_timeout", 32'(timeout), 32'(k == 4));
        end
        tick();
        dv = 1'b0;
        @(negedge clk);
        chk("t4_after_grant", 32'(grant), 32'd0);
        chk("t4_after_timeout", 32'(timeout), 32'd0);

        // Instruction request withdrawn mid-access; pending data request served next
        tick();
        iv = 1'b1; ia = 32'hA0; dv = 1'b1; da = 32'hB0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t6_grant_i", 32'(grant), 32'd1);
        chk("t6_mvalid", 32'(mem_valid), 32'd1);
        tick();
        iv = 1'b0;
        @(negedge clk);
        chk("t6_drop_mvalid", 32'(mem_valid), 32'd0);
        chk("t6_drop_timeout", 32'(timeout), 32'd0);
        tick();
        @(negedge clk);
        chk("t6_idle_grant", 32'(grant), 32'd0);
        tick();
        mrdy = 1'b1;
        push(2'b10, 32'hB0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_grant_d", 32'(grant), 32'd2);
        tick();
        dv = 1'b0; mrdy = 1'b0;
        @(negedge clk);
        chk("t6_end_grant", 32'(grant), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles a granted access may wait for mem_ready_i before abort (1..255).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active low.
REQ-004 imem_valid_i / imem_ready_o  input/output  1/1  instruction-port handshake.
REQ-005 imem_addr_i, imem_wdata_i, imem_we_i, imem_rdata_o  in/in/in/out  `RISCV_ADDR_WIDTH/`RISCV_WORD_WIDTH/4/`RISCV_WORD_WIDTH  instruction-port request and read data.
REQ-006 dmem_valid_i / dmem_ready_o  input/output  1/1  data-port handshake.
REQ-007 dmem_addr_i, dmem_wdata_i, dmem_we_i, dmem_rdata_o  same directions and widths as REQ-005, data port.
REQ-008 mem_valid_o / mem_ready_i  output/input  1/1  shared single-port RAM handshake.
REQ-009 mem_addr_o, mem_wdata_o, mem_we_o, mem_rdata_i  out/out/out/in  same widths as REQ-005, RAM side.
REQ-010 timeout_o  output  1  one-cycle pulse on watchdog abort.
REQ-011 grant_o  output  2  {d_granted, i_granted}, one-hot or zero.

Function
REQ-012 States IDLE, BUSY_I, BUSY_D; one access in flight at most.
REQ-013 IDLE: mem_valid_o=0, both ready outputs 0; if any valid_i high, move to BUSY of the winner next cycle (1-cycle arbitration latency).
REQ-014 Single requester wins outright; both requesting -> round robin: grant the port not recorded in last_grant.
REQ-015 BUSY_x: mem_valid_o=x_valid_i; mem_addr_o/mem_wdata_o/mem_we_o driven from port x; x_ready_o=mem_ready_i combinationally; other port ready=0.
REQ-016 When not BUSY, mem_addr_o, mem_wdata_o, mem_we_o SHALL be 0.
REQ-017 mem_rdata_i broadcast to imem_rdata_o and dmem_rdata_o; valid only for the granted port in its handshake cycle.
REQ-018 BUSY_x with x_valid_i && mem_ready_i: handshake completes, last_grant<=x, state<=IDLE; no back-to-back grant without passing IDLE.
REQ-019 BUSY_x with x_valid_i=0 (protocol violation): mem_valid_o=0, state<=IDLE next cycle, last_grant unchanged.
REQ-020 Wait counter (8 bit) clears on entry to BUSY, increments each BUSY cycle without mem_ready_i; reaching TIMEOUT -> timeout_o=1 that cycle, state<=IDLE, last_grant<=x (aborted port loses next tie).
REQ-021 Counter saturates, never wraps; cleared in IDLE.
REQ-022 Requester changes to addr/wdata/we while BUSY are forwarded unmodified; arbiter does not latch request fields.
REQ-023 A request arriving on the non-granted port while BUSY waits; no request is dropped while its valid_i stays high.
REQ-024 Worst-case grant wait for a held request: one full access of the other port plus one IDLE cycle.

Reset
REQ-025 rst_n low at any time, including mid-access: state=IDLE, last_grant=D (instruction port wins first tie), counter=0, timeout_o=0, grant_o=0, mem_valid_o=0, ready outputs 0, forwarded fields 0.
REQ-026 Reset deassertion takes effect on the following rising clk; no output glitch during reset.

Structure
REQ-027 State enum arb_state_e and grant encoding in shared package riscv_pkg; widths from existing `RISCV_ADDR_WIDTH/`RISCV_WORD_WIDTH defines.
REQ-028 Single flat module; no sub-module; round-robin and watchdog inline.

Verification
REQ-029 imem_valid_i=1 alone, addr 0x100, RAM ready after 2 cycles -> grant_o=01 cycle 1, mem_addr_o=0x100, imem_ready_o high exactly one cycle, then IDLE.
REQ-030 Both valid from reset, addr I=0x10, D=0x20, RAM ready immediate -> order I,D,I,D; mem_addr_o alternates 0x10/0x20, one IDLE cycle between accesses.
REQ-031 dmem write we=4'b0011 wdata=0xDEADBEEF while imem pending -> mem_we_o=0011, mem_wdata_o=0xDEADBEEF, imem_ready_o=0 throughout.
REQ-032 TIMEOUT=4, RAM never ready, dmem request -> timeout_o pulse after 4 BUSY cycles, IDLE next, dmem_ready_o never asserted.
REQ-033 rst_n low mid BUSY_D -> all outputs 0 immediately; after release, simultaneous requests grant I first.
REQ-034 imem_valid_i dropped in BUSY_I before ready -> mem_valid_o=0 same cycle, IDLE next cycle, pending dmem granted after.
